// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO and its storage.
package async_fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 16;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int unsigned width = FIFO_WIDTH,
    parameter int unsigned depth = FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [$clog2(depth)-1:0]   waddr_i,
    input  logic [width-1:0]           wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(depth)-1:0]   raddr_i,
    output logic [width-1:0]           rdata_o
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] rdata_q;

    // Storage is deliberately left unreset; only the output register clears.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO: wrap-bit pointers, full/empty decode and accept logic.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned width = FIFO_WIDTH,
    parameter int unsigned depth = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [width-1:0] w_data,
    input  logic             r_en,
    output logic [width-1:0] r_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = fifo_ptr_width(depth);

    if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
        $error("async_fifo: depth must be a power of two and at least 2");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          w_acc, r_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Acceptance uses pre-edge status only: no bypass, no same-cycle lookahead.
    assign w_acc = w_en && !full  && !rst;
    assign r_acc = r_en && !empty && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (r_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    async_fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (w_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (w_data),
        .re_i    (r_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (r_data)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: queue model of contents and read results.
module tb_async_fifo;

    localparam int unsigned W = 8;
    localparam int unsigned D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         w_en = 1'b0;
    logic [W-1:0] w_data = '0;
    logic         r_en = 1'b0;
    logic [W-1:0] r_data;
    logic         full;
    logic         empty;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];     // model of stored entries
    logic [W-1:0] exp_q[$];  // expected read results, oldest first
    logic [W-1:0] last_rd = '0;

    async_fifo #(
        .width (W),
        .depth (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .w_en   (w_en),
        .w_data (w_data),
        .r_en   (r_en),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle, update the model from pre-edge state, sample 1ns after the edge.
    task automatic cycle(input logic w, input logic [W-1:0] wd, input logic r,
                         input logic rs, output logic racc);
        logic wacc;
        rst    = rs;
        w_en   = w;
        w_data = wd;
        r_en   = r;
        wacc = w && !rs && (mq.size() < D);
        racc = r && !rs && (mq.size() > 0);
        if (rs) begin
            mq.delete();
            exp_q.delete();
            last_rd = '0;
        end
        if (racc) begin
            exp_q.push_back(mq[0]);
            last_rd = mq[0];
            void'(mq.pop_front());
        end
        if (wacc) mq.push_back(wd);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        logic acc;
        logic [W-1:0] hold;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", r_data); end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        hold = last_rd;
        checks++; if (acc !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL read_empty_flag got %b exp 1", empty); end
        checks++; if (r_data !== hold) begin errors++; $display("FAIL read_empty_rdata got %h exp %h", r_data, hold); end
    endtask

    task automatic test_fill();
        logic acc;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b0, acc);
            checks++;
            if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); end
            checks++;
            if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 15); end
        end
    endtask

    task automatic test_write_full();
        logic acc;
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, acc);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wfull_full got %b exp 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL wfull_empty got %b exp 0", empty); end
        // Full and read together: read accepted, write must still be dropped.
        cycle(1'b1, 8'hAB, 1'b1, 1'b0, acc);
        if (acc) begin
            logic [W-1:0] e = exp_q.pop_front();
            checks++; if (r_data !== e) begin errors++; $display("FAIL wfull_rw_rdata got %h exp %h", r_data, e); end
        end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wfull_rw_full got %b exp 0", full); end
        cycle(1'b1, 8'h10, 1'b0, 1'b0, acc);
    endtask

    task automatic test_drain();
        logic acc;
        int n = mq.size();
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            if (acc) begin
                logic [W-1:0] e = exp_q.pop_front();
                checks++;
                if (r_data !== e) begin errors++; $display("FAIL drain_rdata[%0d] got %h exp %h", i, r_data, e); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        checks++; if (r_data !== last_rd) begin errors++; $display("FAIL drain_extra_rdata got %h exp %h", r_data, last_rd); end
    endtask

    task automatic test_wrap_simultaneous();
        logic acc;
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h0A + i), 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, W'(8'h14 + i), 1'b1, 1'b0, acc);
            if (acc) begin
                logic [W-1:0] e = exp_q.pop_front();
                checks++;
                if (r_data !== e) begin errors++; $display("FAIL simul_rdata[%0d] got %h exp %h", i, r_data, e); end
            end
            checks++;
            if (full !== 1'b0 || empty !== 1'b0) begin
                errors++; $display("FAIL simul_flags[%0d] got full=%b empty=%b exp 0 0", i, full, empty);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            if (acc) begin
                logic [W-1:0] e = exp_q.pop_front();
                checks++;
                if (r_data !== e) begin errors++; $display("FAIL simul_drain[%0d] got %h exp %h", i, r_data, e); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_final_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h30 + i), 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h77, 1'b1, 1'b1, acc);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full got %b exp 0", full); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL midrst_rdata got %h exp 00", r_data); end
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        if (acc) begin
            logic [W-1:0] e = exp_q.pop_front();
            checks++; if (r_data !== e) begin errors++; $display("FAIL midrst_read got %h exp %h", r_data, e); end
        end else begin
            checks++; errors++; $display("FAIL midrst_read_acc got 0 exp 1");
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_after_empty got %b exp 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                logic [W-1:0] e = exp_q.pop_front();
                checks++;
                if (r_data !== e) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, r_data, e); end
            end else begin
                checks++;
                if (r_data !== last_rd) begin errors++; $display("FAIL b2b_hold[%0d] got %h exp %h", i, r_data, last_rd); end
            end
            checks++;
            if (full !== (mq.size() == D) || empty !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL b2b_flags[%0d] got full=%b empty=%b exp %b %b",
                         i, full, empty, mq.size() == D, mq.size() == 0);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_write_full();
        test_drain();
        test_wrap_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
